pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 41 ++++
 rtl/ret_stack.sv | 75 +++++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage program-counter sequencer.
package pc_seq_pkg;

  localparam int D_DEF           = 12;
  localparam int NUM_TARGETS_DEF = 10;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } pc_state_t;

  // Control operations in priority order: a lower value wins over a higher one.
  typedef enum logic [2:0] {
    CTL_STALL  = 3'd0,
    CTL_HALT   = 3'd1,
    CTL_RET    = 3'd2,
    CTL_CALL   = 3'd3,
    CTL_JUMP   = 3'd4,
    CTL_BRANCH = 3'd5,
    CTL_STEP   = 3'd6
  } ctl_op_t;

  // Collapse the raw control strobes into the single winning operation.
  function automatic ctl_op_t ctl_decode(input logic stall, input logic halt,
                                         input logic ret, input logic call,
                                         input logic jump, input logic taken);
    ctl_op_t op;
    if (stall)      op = CTL_STALL;
    else if (halt)  op = CTL_HALT;
    else if (ret)   op = CTL_RET;
    else if (call)  op = CTL_CALL;
    else if (jump)  op = CTL_JUMP;
    else if (taken) op = CTL_BRANCH;
    else            op = CTL_STEP;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: clear wins over push, push over pop; overflow and
// underflow requests are ignored here (the sequencer faults before issuing them).
module ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     depth
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] depth_q;
  logic [CNT_W-1:0] depth_d;
  logic [WIDTH-1:0] top_s;

  assign full  = (depth_q == CNT_W'(DEPTH));
  assign empty = (depth_q == {CNT_W{1'b0}});
  assign depth = depth_q;
  assign top   = top_s;

  // Top-of-stack read: the entry just below the occupancy count.
  always_comb begin
    top_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CNT_W'(i + 1)) begin
        top_s = mem_q[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Next-state for storage and occupancy.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = {WIDTH{1'b0}};
      depth_d = {CNT_W{1'b0}};
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_q == CNT_W'(i)) mem_d[i] = push_data;
        else                      mem_d[i] = mem_q[i];
      end
      depth_d = depth_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      depth_d = depth_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      depth_d = depth_q;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: {WIDTH{1'b0}}};
      depth_q <= {CNT_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: run/done/fault FSM, next-PC mux and call/return stack.
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int D           = D_DEF,
  parameter int NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic                               Start,
  input  logic                               Stall,
  input  logic                               Halt,
  input  logic                               Jump,
  input  logic                               Branch,
  input  logic                               CondFlag,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic [3:0]                         LutSel,
  input  logic [D-1:0]                       LutTarget,
  output logic [3:0]                         LutIdx,
  output logic [D-1:0]                       PC,
  output logic                               Busy,
  output logic                               Done,
  output logic                               Fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth
);

  localparam int DW = $clog2(STACK_DEPTH+1);

  pc_state_t      state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic           busy_q, done_q, fault_q;
  logic [D-1:0]   pc_inc_s, top_s;
  logic           push_s, pop_s, clr_s;
  logic           full_s, empty_s, lut_bad_s;
  logic [DW-1:0]  depth_s;
  ctl_op_t        op_s;

  assign LutIdx    = LutSel;
  assign pc_inc_s  = pc_q + {{(D-1){1'b0}}, 1'b1};
  assign lut_bad_s = ({28'd0, LutSel} >= 32'(NUM_TARGETS));
  assign op_s      = ctl_decode(Stall, Halt, Ret, Call, Jump, Branch & CondFlag);

  assign PC    = pc_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Fault = fault_q;
  assign Depth = depth_s;

  ret_stack #(.WIDTH(D), .DEPTH(STACK_DEPTH)) u_ret_stack (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clear     (clr_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .top       (top_s),
    .full      (full_s),
    .empty     (empty_s),
    .depth     (depth_s)
  );

  // Next state, next PC and stack strobes; on any fault PC keeps the offending address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      RUN: begin
        case (op_s)
          CTL_STALL: state_d = RUN;
          CTL_HALT:  state_d = DONE;
          CTL_RET: begin
            if (empty_s) begin
              state_d = FAULT;
            end else begin
              pc_d  = top_s;
              pop_s = 1'b1;
            end
          end
          CTL_CALL: begin
            if (full_s || lut_bad_s) begin
              state_d = FAULT;
            end else begin
              pc_d   = LutTarget;
              push_s = 1'b1;
            end
          end
          CTL_JUMP, CTL_BRANCH: begin
            if (lut_bad_s) state_d = FAULT;
            else           pc_d    = LutTarget;
          end
          CTL_STEP: pc_d    = pc_inc_s;
          default:  state_d = FAULT;
        endcase
      end
      IDLE, DONE, FAULT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = {D{1'b0}};
          clr_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = {D{1'b0}};
        clr_s   = 1'b1;
      end
    endcase
  end

  // FSM state, PC and registered status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= {D{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      fault_q <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected
// PC/status per driven cycle, popped and compared one edge later.
module tb_pc_sequencer;

  localparam logic [7:0] C_START = 8'h01;
  localparam logic [7:0] C_STALL = 8'h02;
  localparam logic [7:0] C_HALT  = 8'h04;
  localparam logic [7:0] C_JUMP  = 8'h08;
  localparam logic [7:0] C_BR    = 8'h10;
  localparam logic [7:0] C_CF    = 8'h20;
  localparam logic [7:0] C_CALL  = 8'h40;
  localparam logic [7:0] C_RET   = 8'h80;
  localparam logic [7:0] C_NONE  = 8'h00;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0, Stall = 1'b0, Halt = 1'b0, Jump = 1'b0;
  logic        Branch = 1'b0, CondFlag = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [3:0]  LutSel = 4'd0;
  logic [11:0] LutTarget = 12'd0;
  logic [3:0]  LutIdx;
  logic [11:0] PC;
  logic        Busy, Done, Fault;
  logic [2:0]  Depth;

  pc_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .Jump(Jump), .Branch(Branch), .CondFlag(CondFlag), .Call(Call), .Ret(Ret),
    .LutSel(LutSel), .LutTarget(LutTarget), .LutIdx(LutIdx), .PC(PC),
    .Busy(Busy), .Done(Done), .Fault(Fault), .Depth(Depth)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [11:0] pc;
    logic [2:0]  dep;
    logic        busy;
    logic        done;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: 0 idle, 1 run, 2 done, 3 fault.
  int          m_st = 0;
  logic [11:0] m_pc = 12'd0;
  logic [11:0] m_stk[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] c, input logic [3:0] sel, input logic [11:0] tgt);
    bit bad_sel;
    bad_sel = (sel >= 4'd10);
    if (m_st != 1) begin
      if (c[0]) begin
        m_st = 1;
        m_pc = 12'd0;
        m_stk.delete();
      end
    end else if (c[1]) begin
      m_st = 1;
    end else if (c[2]) begin
      m_st = 2;
    end else if (c[7]) begin
      if (m_stk.size() == 0) m_st = 3;
      else m_pc = m_stk.pop_back();
    end else if (c[6]) begin
      if (m_stk.size() == 4 || bad_sel) m_st = 3;
      else begin
        m_stk.push_back(m_pc + 12'd1);
        m_pc = tgt;
      end
    end else if (c[3] || (c[4] && c[5])) begin
      if (bad_sel) m_st = 3;
      else m_pc = tgt;
    end else begin
      m_pc = m_pc + 12'd1;
    end
  endtask

  // One clock: drive, predict into the scoreboard, then compare after the edge.
  task automatic cyc(input string tag, input logic [7:0] c, input logic [3:0] sel,
                     input logic [11:0] tgt);
    exp_t e;
    Start = c[0]; Stall = c[1]; Halt = c[2]; Jump = c[3];
    Branch = c[4]; CondFlag = c[5]; Call = c[6]; Ret = c[7];
    LutSel = sel; LutTarget = tgt;
    #1;
    check({tag, "/lutidx"}, 32'(LutIdx), 32'(sel));
    model_step(c, sel, tgt);
    e.tag = tag; e.pc = m_pc; e.dep = 3'(m_stk.size());
    e.busy = (m_st == 1); e.done = (m_st == 2); e.fault = (m_st == 3);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, "/pc"},    32'(PC),    32'(e.pc));
    check({e.tag, "/depth"}, 32'(Depth), 32'(e.dep));
    check({e.tag, "/busy"},  32'(Busy),  32'(e.busy));
    check({e.tag, "/done"},  32'(Done),  32'(e.done));
    check({e.tag, "/fault"}, 32'(Fault), 32'(e.fault));
  endtask

  initial begin
    #12;
    check("rst/pc", 32'(PC), 32'd0);
    check("rst/status", 32'({Busy, Done, Fault, Depth}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    cyc("idle_hold", C_NONE, 4'd0, 12'd0);
    cyc("start", C_START, 4'd0, 12'd0);
    for (int i = 0; i < 10; i++) cyc("step", C_NONE, 4'd0, 12'd0);
    check("pc_after_10", 32'(PC), 32'd10);
    cyc("halt", C_HALT, 4'd0, 12'd0);
    check("halt_done", 32'({Done, PC}), 32'h100A);
    cyc("done_stall", C_STALL | C_JUMP, 4'd4, 12'd99);
    cyc("done_hold", C_NONE, 4'd0, 12'd0);

    cyc("restart", C_START, 4'd0, 12'd0);
    cyc("jump", C_JUMP, 4'd4, 12'd102);
    check("jump_pc", 32'(PC), 32'd102);
    cyc("br_nt", C_BR, 4'd2, 12'd61);
    check("br_nt_pc", 32'(PC), 32'd103);
    cyc("br_t", C_BR | C_CF, 4'd2, 12'd61);
    check("br_t_pc", 32'(PC), 32'd61);

    cyc("to20", C_JUMP, 4'd1, 12'd20);
    cyc("call", C_CALL, 4'd3, 12'd73);
    check("call_pc", 32'({Depth, PC}), 32'h1049);
    cyc("ret", C_RET, 4'd0, 12'd0);
    check("ret_pc", 32'({Depth, PC}), 32'd21);
    for (int i = 1; i <= 4; i++) cyc("nest", C_CALL, 4'd5, 12'(100 * i));
    check("nest_depth", 32'(Depth), 32'd4);
    cyc("call_ovf", C_CALL, 4'd5, 12'd500);
    check("ovf_fault", 32'({Fault, PC}), 32'h1190);
    cyc("fault_hold", C_STALL, 4'd0, 12'd0);

    cyc("start_f", C_START, 4'd0, 12'd0);
    check("start_f_clean", 32'({Busy, Depth, PC}), 32'h8000);
    cyc("ret_udf", C_RET, 4'd0, 12'd0);
    cyc("start_f2", C_START, 4'd0, 12'd0);
    cyc("jump_bad", C_JUMP, 4'd12, 12'd7);
    check("jump_bad_fault", 32'(Fault), 32'd1);
    cyc("start_f3", C_START, 4'd0, 12'd0);
    cyc("br_bad_nt", C_BR, 4'd15, 12'd7);
    cyc("call_bad", C_CALL, 4'd10, 12'd7);
    cyc("start_f4", C_START, 4'd0, 12'd0);

    cyc("pre_stall", C_NONE, 4'd0, 12'd0);
    for (int i = 0; i < 3; i++) cyc("stall_jump", C_STALL | C_JUMP, 4'd4, 12'd300);
    check("stall_pc", 32'(PC), 32'd1);
    cyc("stall_halt", C_STALL | C_HALT, 4'd0, 12'd0);
    check("stall_halt_run", 32'({Busy, Done}), 32'd2);
    cyc("halt2", C_HALT, 4'd0, 12'd0);
    cyc("start_w", C_START, 4'd0, 12'd0);
    cyc("to_max", C_JUMP, 4'd9, 12'hFFF);
    cyc("wrap", C_NONE, 4'd0, 12'd0);
    check("wrap_pc", 32'({Fault, PC}), 32'd0);

    // Constrained-random run, restarting whenever the model leaves RUN.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      c = C_NONE;
      if (m_st != 1 || $urandom_range(0, 15) == 0) c |= C_START;
      if ($urandom_range(0, 7) == 0)  c |= C_STALL;
      if ($urandom_range(0, 24) == 0) c |= C_HALT;
      if ($urandom_range(0, 5) == 0)  c |= C_RET;
      if ($urandom_range(0, 4) == 0)  c |= C_CALL;
      if ($urandom_range(0, 7) == 0)  c |= C_JUMP;
      if ($urandom_range(0, 5) == 0)  c |= C_BR;
      if ($urandom_range(0, 1) == 0)  c |= C_CF;
      cyc("rand", c, 4'($urandom_range(0, 11)), 12'($urandom_range(0, 4095)));
    end

    cyc("start_r", C_START, 4'd0, 12'd0);
    cyc("to50", C_JUMP, 4'd1, 12'd50);
    cyc("c55", C_CALL, 4'd1, 12'd55);
    cyc("c56", C_CALL, 4'd1, 12'd56);
    cyc("s57", C_NONE, 4'd0, 12'd0);
    check("pre_rst", 32'({Depth, PC}), 32'h2039);
    #2;
    Reset_n = 1'b0;
    #1;
    m_st = 0; m_pc = 12'd0; m_stk.delete();
    check("midrst/pc", 32'(PC), 32'd0);
    check("midrst/status", 32'({Busy, Done, Fault, Depth}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    cyc("post_rst_idle", C_NONE, 4'd3, 12'd9);
    cyc("post_rst_start", C_START, 4'd0, 12'd0);
    cyc("post_rst_step", C_NONE, 4'd0, 12'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
